// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave with an auto-incrementing 8-bit register file, oversampled in clk.
// Actions land one clk after the synchronised sclk edge; no backpressure (the SPI master paces everything).
module spi_reg_slave #(
   parameter int          NUM_REGS  = 8,
   parameter int          AW        = 3,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cs,
   output logic                  miso,
   output logic [8*NUM_REGS-1:0] regs_out,
   output logic                  wr_pulse,
   output logic [AW-1:0]         wr_addr,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

   state_t                state;
   logic [2:0]            sclk_sy;
   logic [1:0]            mosi_sy;
   logic [2:0]            cs_sy;
   logic [8*NUM_REGS-1:0] regs_q;
   logic [2:0]            bit_cnt;
   logic [6:0]            rx_sh;
   logic [6:0]            tx_sh;
   logic [AW-1:0]         ptr;
   logic                  need_load;

   logic       sclk_rise, sclk_fall, cs_hi, cs_fall;
   logic [7:0] rx_byte, rd_byte;

   // Synchroniser flops are deliberately not reset so cs history survives rst:
   // a frame already in progress at reset must not look like a fresh cs fall.
   always_ff @(posedge clk) begin
      sclk_sy <= {sclk_sy[1:0], sclk};
      mosi_sy <= {mosi_sy[0], mosi};
      cs_sy   <= {cs_sy[1:0], cs};
   end

   assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
   assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
   assign cs_hi     = cs_sy[1];
   assign cs_fall   = ~cs_sy[1] & cs_sy[2];
   assign rx_byte   = {rx_sh, mosi_sy[1]};
   assign rd_byte   = regs_q[{ptr, 3'b000} +: 8];
   assign regs_out  = regs_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         regs_q    <= {NUM_REGS{RESET_VAL}};
         miso      <= 1'b0;
         wr_pulse  <= 1'b0;
         wr_addr   <= '0;
         busy      <= 1'b0;
         bit_cnt   <= 3'd0;
         rx_sh     <= 7'd0;
         tx_sh     <= 7'd0;
         ptr       <= '0;
         need_load <= 1'b0;
      end else begin
         wr_pulse <= 1'b0;
         if (state == IDLE) begin
            miso    <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 3'd0;
            if (cs_fall) begin
               state <= CMD;
               busy  <= 1'b1;
            end
         end else if (cs_hi) begin
            // cs wins over any coincident sclk edge; a partial byte is dropped
            state   <= IDLE;
            busy    <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= 3'd0;
         end else begin
            if (sclk_rise) begin
               rx_sh   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  case (state)
                     CMD: begin
                        ptr       <= rx_byte[AW-1:0];
                        state     <= rx_byte[7] ? RDATA : WDATA;
                        need_load <= rx_byte[7];
                     end
                     WDATA: begin
                        regs_q[{ptr, 3'b000} +: 8] <= rx_byte;
                        wr_pulse <= 1'b1;
                        wr_addr  <= ptr;
                        ptr      <= ptr + 1'b1;
                     end
                     default: begin
                        ptr       <= ptr + 1'b1;
                        need_load <= 1'b1;
                     end
                  endcase
               end
            end
            if (sclk_fall && state == RDATA) begin
               if (need_load) begin
                  tx_sh     <= rd_byte[6:0];
                  miso      <= rd_byte[7];
                  need_load <= 1'b0;
               end else begin
                  tx_sh <= {tx_sh[5:0], 1'b0};
                  miso  <= tx_sh[6];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a mode-0 master task drives frames, and monitors
// compare write strobes and received MISO bytes against queued expectations.
module tb_spi_reg_slave;
   localparam int NR   = 8;
   localparam int AW   = 3;
   localparam int HALF = 8;

   logic            clk = 1'b0;
   logic            rst, sclk, mosi, cs;
   logic            miso, wr_pulse, busy;
   logic [8*NR-1:0] regs_out;
   logic [AW-1:0]   wr_addr;

   always #5 clk = ~clk;

   spi_reg_slave #(.NUM_REGS(NR), .AW(AW), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
      .miso(miso), .regs_out(regs_out), .wr_pulse(wr_pulse),
      .wr_addr(wr_addr), .busy(busy)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   int         checks = 0;
   int         errors = 0;
   wr_t        wr_q[$];
   logic [7:0] rx_exp_q[$];
   logic [7:0] rx_got_q[$];
   logic [7:0] model[NR];
   logic [7:0] tx_bytes[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [8*NR-1:0] model_flat();
      logic [8*NR-1:0] r;
      for (int i = 0; i < NR; i++) r[8*i +: 8] = model[i];
      return r;
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         clks(HALF);
         sclk = 1'b1;
         rx   = {rx[6:0], miso};
         clks(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic run_frame();
      logic [7:0] rx;
      cs = 1'b0;
      clks(HALF);
      check("busy_in_frame", {63'd0, busy}, 64'd1);
      foreach (tx_bytes[k]) begin
         xfer_bits(tx_bytes[k], 8, rx);
         rx_got_q.push_back(rx);
      end
      clks(HALF);
      cs = 1'b1;
      clks(HALF);
      check("busy_after_cs", {63'd0, busy}, 64'd0);
      tx_bytes.delete();
   endtask

   task automatic write_frame(input logic [7:0] cmd, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2, input int n);
      logic [AW-1:0] p;
      logic [7:0]    d;
      p = cmd[AW-1:0];
      tx_bytes.push_back(cmd);
      rx_exp_q.push_back(8'h00);
      for (int k = 0; k < n; k++) begin
         d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
         tx_bytes.push_back(d);
         rx_exp_q.push_back(8'h00);
         wr_q.push_back('{addr: p, data: d});
         model[p] = d;
         p = p + 1'b1;
      end
      run_frame();
   endtask

   task automatic read_frame(input logic [7:0] cmd, input int n);
      logic [AW-1:0] p;
      p = cmd[AW-1:0];
      tx_bytes.push_back(cmd);
      rx_exp_q.push_back(8'h00);
      for (int k = 0; k < n; k++) begin
         tx_bytes.push_back(8'h00);
         rx_exp_q.push_back(model[p]);
         p = p + 1'b1;
      end
      run_frame();
   endtask

   // Write-strobe monitor
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (wr_pulse) begin
            if (wr_q.size() == 0) begin
               check("unexpected_wr_pulse", {61'd0, wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = wr_q.pop_front();
               check("wr_addr", {61'd0, wr_addr}, {61'd0, e.addr});
               check("wr_data", {56'd0, regs_out[{wr_addr, 3'b000} +: 8]}, {56'd0, e.data});
            end
         end
      end
   end

   // MISO byte monitor
   initial begin
      logic [7:0] got, exp;
      forever begin
         @(negedge clk);
         while (rx_got_q.size() > 0) begin
            got = rx_got_q.pop_front();
            if (rx_exp_q.size() == 0) begin
               check("unexpected_rx", {56'd0, got}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp = rx_exp_q.pop_front();
               check("miso_byte", {56'd0, got}, {56'd0, exp});
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rx;
      for (int i = 0; i < NR; i++) model[i] = 8'h00;
      rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;

      // Reset state
      clks(3);
      check("reset_regs", regs_out, 64'd0);
      check("reset_miso", {63'd0, miso}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_wr_pulse", {63'd0, wr_pulse}, 64'd0);
      rst = 1'b1;
      clks(4);

      // Single write
      write_frame(8'h03, 8'hA5, 8'h00, 8'h00, 1);
      check("regs_single_write", regs_out, model_flat());

      // Burst write with wrap 6,7,0
      write_frame(8'h06, 8'h11, 8'h22, 8'h33, 3);
      check("regs_burst_wrap", regs_out, model_flat());

      // Preload then burst read
      write_frame(8'h01, 8'h5A, 8'hC3, 8'h00, 2);
      read_frame(8'h81, 2);
      check("regs_after_read", regs_out, model_flat());

      // Abort mid data byte
      cs = 1'b0;
      clks(HALF);
      xfer_bits(8'h02, 8, rx);
      rx_exp_q.push_back(8'h00);
      rx_got_q.push_back(rx);
      xfer_bits(8'hFF, 4, rx);
      cs = 1'b1;
      clks(HALF);
      check("busy_after_abort", {63'd0, busy}, 64'd0);
      check("regs_after_abort", regs_out, model_flat());
      write_frame(8'h02, 8'h7E, 8'h00, 8'h00, 1);
      check("regs_after_retry", regs_out, model_flat());

      // Reset in the middle of a write burst
      rx_exp_q.push_back(8'h00);
      rx_exp_q.push_back(8'h00);
      rx_exp_q.push_back(8'h00);
      wr_q.push_back('{addr: 3'd0, data: 8'h11});
      cs = 1'b0;
      clks(HALF);
      xfer_bits(8'h00, 8, rx);
      rx_got_q.push_back(rx);
      xfer_bits(8'h11, 8, rx);
      rx_got_q.push_back(rx);
      clks(2);
      rst = 1'b0;
      clks(1);
      rst = 1'b1;
      for (int i = 0; i < NR; i++) model[i] = 8'h00;
      check("regs_after_midreset", regs_out, 64'd0);
      check("busy_after_midreset", {63'd0, busy}, 64'd0);
      xfer_bits(8'h22, 8, rx);
      rx_got_q.push_back(rx);
      clks(HALF);
      check("regs_ignored_after_reset", regs_out, 64'd0);
      check("busy_ignored_after_reset", {63'd0, busy}, 64'd0);
      cs = 1'b1;
      clks(HALF);
      write_frame(8'h05, 8'h99, 8'h00, 8'h00, 1);
      check("regs_final", regs_out, model_flat());

      clks(20);
      check("wr_q_drained", 64'(wr_q.size()), 64'd0);
      check("rx_q_drained", 64'(rx_exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI mode-0 slave (CPOL=0, CPHA=0) that responds to the existing SPI master with a small addressable register file.
- Each frame (cs low) is a command byte followed by one or more data bytes, with a write or read burst and auto-incrementing address.
- SPI pins are oversampled in the system clk domain.
- The register contents are exported in parallel to the surrounding logic, which uses them as configuration.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; must be a power of two, 2..128.
- AW, 3, address width, equal to log2(NUM_REGS).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock; sclk half-period is at least 4 clk cycles.
- rst  input  1  synchronous, active-low reset.
- sclk  input  1  SPI clock from the master, asynchronous to clk.
- mosi  input  1  serial data from the master, MSB first.
- cs  input  1  active-low chip select.
- miso  output  1  serial data to the master, MSB first.
- regs_out  output  8*NUM_REGS  flattened register file; reg[i] sits at bits [8i+7:8i].
- wr_pulse  output  1  one-clk strobe when a register is written.
- wr_addr  output  AW  address of the latest write, valid with wr_pulse.
- busy  output  1  high while a frame is active.

Behaviour:
- Synchronisation:
  - sclk, mosi and cs each pass through a 2-flop synchroniser.
  - Rising and falling sclk edges are detected from the synchronised sclk.
  - All actions below occur on the clk cycle after edge detection.
- Reset (rst=0 at a clk edge), regardless of frame state:
  - State goes to IDLE; all registers take RESET_VAL.
  - miso=0, wr_pulse=0, wr_addr=0, busy=0; bit counter and shift registers are cleared.
- States:
  - IDLE: entered on reset or synchronised cs high. Goes to CMD on synchronised cs falling; busy goes high in that transition.
  - CMD: shifts mosi in on 8 sclk rising edges. Command byte = {rw, addr[6:0]}, with rw=1 meaning read. Only addr[AW-1:0] is used; upper address bits are ignored. After the 8th bit, pointer = addr[AW-1:0] and the state goes to WDATA or RDATA.
  - WDATA: shifts 8 bits in. On the 8th rising edge, reg[pointer] is updated on the next clk, together with wr_pulse=1 for one cycle and wr_addr=pointer. The pointer then increments modulo NUM_REGS. Further bytes continue the burst.
  - RDATA: at the first sclk falling edge after the command byte (and after each completed data byte), reg[pointer] is loaded into the TX shift register and its MSB is driven on miso. Each subsequent falling edge shifts the next bit out. After the 8th rising edge the pointer increments modulo NUM_REGS, and the next byte is loaded on the following falling edge. The value sent is a snapshot taken at load time.
- miso:
  - 0 in IDLE and during CMD.
  - Holds the last driven bit until the next falling edge.
  - Returns to 0 when cs goes high.
- cs rises mid-byte (synchronised): the frame is aborted.
  - A partial write byte is discarded; no register changes and no wr_pulse.
  - State goes to IDLE; busy goes low the same cycle.
- Frame ends with 0 data bytes (cs high right after the command byte): no effect.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- sclk edges while cs is high are ignored.
- Simultaneous cs rise and sclk edge: cs has priority and the edge is ignored.
- Writes take effect only at full byte boundaries. regs_out updates in the cycle after the 8th synchronised rising edge.
- There are no external write ports; only SPI modifies the registers.

Test Plan:
1. Reset: hold rst=0 for 3 clk with cs high → regs_out all 8'h00, miso=0, busy=0, wr_pulse=0.
2. Single write: frame 0x03, 0xA5 → reg[3]=0xA5; exactly one wr_pulse with wr_addr=3; all other registers stay 0x00; busy falls after cs rises.
3. Burst write with wrap: frame 0x06, 0x11, 0x22, 0x33 → reg6=0x11, reg7=0x22, reg0=0x33; three wr_pulses with wr_addr 6, 7, 0.
4. Burst read with the existing master:
   - Preload reg1=0x5A and reg2=0xC3.
   - Read frame 0x81, 0x00, 0x00 → master o_dataout shows 0x00 during the command byte, then 0x5A, then 0xC3; registers unchanged.
5. Abort: frame 0x02 then 4 data bits of 0xFF, then cs high → reg2 unchanged, no wr_pulse. The next frame 0x02, 0x7E succeeds with reg2=0x7E.
6. Mid-frame reset: during a write burst, assert rst=0 for 1 clk after byte 1 has been written → all registers return to 0x00 and the state is IDLE. Remaining bits are ignored until cs goes high then low again, after which a new frame works normally.
